// File: rtl/peri_timer_pkg.sv
// peri_timer_pkg: shared constants and types for the machine timer.
// Register indices, CTRL/STATUS bit positions, 64-bit time type, byte merge.
package peri_timer_pkg;

    localparam logic [2:0] REG_CTRL        = 3'd0;
    localparam logic [2:0] REG_PRESCALE    = 3'd1;
    localparam logic [2:0] REG_MTIME_LO    = 3'd2;
    localparam logic [2:0] REG_MTIME_HI    = 3'd3;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd4;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd5;
    localparam logic [2:0] REG_STATUS      = 3'd6;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int CTRL_W           = 3;

    localparam int STATUS_PENDING = 0;

    typedef logic [63:0] mtime_t;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/peri_timer_prescaler.sv
// peri_timer_prescaler: divides clk by (prescale+1) while enabled.
// Ports: clk, rst_n, en, prescale in; tick out (one cycle per period).
module peri_timer_prescaler #(
    parameter int PrescaleWidth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [PrescaleWidth-1:0] prescale,
    output logic                     tick
);

    logic [PrescaleWidth-1:0] pcnt_q;

    assign tick = en && (pcnt_q == prescale);

    // Disabled forces the count back to zero so a
    // re-enable always starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (!en || tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/peri_timer.sv
// peri_timer: memory-mapped 64-bit machine timer on the peripheral bus.
// Ports: clk, rst_n; peri_req/addr/write/be/wdata in; peri_gnt/rvalid/rdata
// out; timer_irq out. Optional `PERI_TIMER_LATCH_EN: MTIME_LO read latches
// mtime[63:32] so the following MTIME_HI read is atomic.
module peri_timer
    import peri_timer_pkg::*;
#(
    parameter logic [31:0] BaseAddr      = 32'h0000_1000,
    parameter int          WindowBits    = 12,
    parameter int          PrescaleWidth = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        peri_req,
    input  logic [31:0] peri_addr,
    input  logic        peri_write,
    input  logic [3:0]  peri_be,
    input  logic [31:0] peri_wdata,
    output logic        peri_gnt,
    output logic        peri_rvalid,
    output logic [31:0] peri_rdata,
    output logic        timer_irq
);

    localparam logic [31:0] WinMask = (32'd1 << WindowBits) - 32'd1;

    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    mtime_t                   mtime_q, mtime_d;
    mtime_t                   mtimecmp_q, mtimecmp_d;
    logic                     pending_q, pending_d;
    logic                     rvalid_q;
    logic [31:0]              rdata_q, rdata_d;
    logic [31:0]              rd_mux;
    logic [31:0]              mtime_hi_rd;

    logic       hit, wr, rd;
    logic [2:0] idx;
    logic       tick, match, w1c;
    logic       wr_mlo, wr_mhi;

    assign hit = (peri_addr & ~WinMask) == BaseAddr;
    assign idx = peri_addr[4:2];
    assign wr  = peri_req && hit && peri_write;
    assign rd  = peri_req && hit && !peri_write;

    // be=0 must not steal a tick from the counter
    assign wr_mlo = wr && (idx == REG_MTIME_LO) && (|peri_be);
    assign wr_mhi = wr && (idx == REG_MTIME_HI) && (|peri_be);

    assign w1c = wr && (idx == REG_STATUS) && peri_be[0]
               && peri_wdata[STATUS_PENDING];

    peri_timer_prescaler #(
        .PrescaleWidth(PrescaleWidth)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ctrl_q[CTRL_EN]),
        .prescale(prescale_q),
        .tick    (tick)
    );

    // Compare is armed only while counting; otherwise the
    // all-zero reset state would flag a match immediately.
    assign match = ctrl_q[CTRL_EN] && (mtime_q >= mtimecmp_q);

    assign pending_d = match || (pending_q && !w1c);

    always_comb begin
        mtime_d = mtime_q;
        if (tick) begin
            if (ctrl_q[CTRL_AUTO_RELOAD] && match) begin
                mtime_d = '0;
            end else begin
                mtime_d = mtime_q + 64'd1;
            end
        end
        // A software write overrides the tick for the whole
        // counter: written half takes the data, the other half
        // keeps its pre-tick value.
        if (wr_mlo) begin
            mtime_d = {mtime_q[63:32],
                       be_merge(mtime_q[31:0], peri_wdata, peri_be)};
        end else if (wr_mhi) begin
            mtime_d = {be_merge(mtime_q[63:32], peri_wdata, peri_be),
                       mtime_q[31:0]};
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr && (idx == REG_CTRL) && peri_be[0]) begin
            ctrl_d = peri_wdata[CTRL_W-1:0];
        end
    end

    always_comb begin
        prescale_d = prescale_q;
        if (wr && (idx == REG_PRESCALE)) begin
            for (int i = 0; i < PrescaleWidth; i++) begin
                if (peri_be[i/8]) begin
                    prescale_d[i] = peri_wdata[i];
                end
            end
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr && (idx == REG_MTIMECMP_LO)) begin
            mtimecmp_d[31:0] = be_merge(mtimecmp_q[31:0],
                                        peri_wdata, peri_be);
        end
        if (wr && (idx == REG_MTIMECMP_HI)) begin
            mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32],
                                         peri_wdata, peri_be);
        end
    end

`ifdef PERI_TIMER_LATCH_EN
    logic [31:0] shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (rd && (idx == REG_MTIME_LO)) begin
            shadow_q <= mtime_q[63:32];
        end
    end

    assign mtime_hi_rd = shadow_q;
`else
    assign mtime_hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            idx == REG_CTRL:
                rd_mux[CTRL_W-1:0] = ctrl_q;
            idx == REG_PRESCALE:
                rd_mux[PrescaleWidth-1:0] = prescale_q;
            idx == REG_MTIME_LO:
                rd_mux = mtime_q[31:0];
            idx == REG_MTIME_HI:
                rd_mux = mtime_hi_rd;
            idx == REG_MTIMECMP_LO:
                rd_mux = mtimecmp_q[31:0];
            idx == REG_MTIMECMP_HI:
                rd_mux = mtimecmp_q[63:32];
            idx == REG_STATUS:
                rd_mux[STATUS_PENDING] = pending_q;
            default:
                rd_mux = '0;
        endcase
    end

    // Loading zero on idle cycles keeps rdata at 0 whenever
    // rvalid is low, and for writes and misses.
    assign rdata_d = rd ? rd_mux : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '0;
            pending_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pending_q  <= pending_d;
            rvalid_q   <= peri_req;
            rdata_q    <= rdata_d;
        end
    end

    assign peri_gnt    = peri_req;
    assign peri_rvalid = rvalid_q;
    assign peri_rdata  = rdata_q;
    assign timer_irq   = pending_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_peri_timer.sv
// tb_peri_timer: directed + random bus traffic against a reference model.
// Checks handshake, read data, and interrupt every cycle.
module tb_peri_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        rst_n;
    logic        peri_req;
    logic [31:0] peri_addr;
    logic        peri_write;
    logic [3:0]  peri_be;
    logic [31:0] peri_wdata;
    logic        peri_gnt;
    logic        peri_rvalid;
    logic [31:0] peri_rdata;
    logic        timer_irq;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc;
    int          m_phase;
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_pend;
    logic [31:0] m_shadow;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;

    bit          fix_en = 0;
    string       fix_tag;
    logic [31:0] fix_val;

    peri_timer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .peri_req   (peri_req),
        .peri_addr  (peri_addr),
        .peri_write (peri_write),
        .peri_be    (peri_be),
        .peri_wdata (peri_wdata),
        .peri_gnt   (peri_gnt),
        .peri_rvalid(peri_rvalid),
        .peri_rdata (peri_rdata),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = b[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_presc = 0; m_phase = 0;
        m_mtime = 0; m_cmp = 0; m_pend = 0; m_shadow = 0;
        exp_rvalid = 0; exp_rdata = 0;
    endtask

    // One clock edge of the register block, from the register map rules.
    task automatic model_step(input bit req, input bit wr,
                              input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
        bit hit, w, tk, mt;
        int ix;
        logic [31:0] rv, t;
        logic [63:0] nt;
        hit = ((a & 32'hFFFF_F000) == BASE);
        ix = int'(a[4:2]);
        rv = 0;
        if (hit) begin
            case (ix)
                0: rv = {29'd0, m_ctrl};
                1: rv = {16'd0, m_presc};
                2: rv = m_mtime[31:0];
`ifdef PERI_TIMER_LATCH_EN
                3: rv = m_shadow;
`else
                3: rv = m_mtime[63:32];
`endif
                4: rv = m_cmp[31:0];
                5: rv = m_cmp[63:32];
                6: rv = {31'd0, m_pend};
                default: rv = 0;
            endcase
        end
        exp_rvalid = req;
        exp_rdata = (req && !wr) ? rv : 32'd0;
        // enabled cycles counted in phase; a tick closes each period
        tk = m_ctrl[0] && (m_phase == int'(m_presc));
        mt = m_ctrl[0] && (m_mtime >= m_cmp);
        if (!m_ctrl[0] || tk) m_phase = 0;
        else m_phase = (m_phase + 1) % 65536;
        nt = m_mtime;
        if (tk) nt = (m_ctrl[2] && mt) ? 64'd0 : m_mtime + 64'd1;
        w = req && wr && hit;
`ifdef PERI_TIMER_LATCH_EN
        if (req && !wr && hit && ix == 2) m_shadow = m_mtime[63:32];
`endif
        if (w && b != 0 && ix == 2)
            nt = {m_mtime[63:32], merge(m_mtime[31:0], d, b)};
        if (w && b != 0 && ix == 3)
            nt = {merge(m_mtime[63:32], d, b), m_mtime[31:0]};
        m_pend = mt || (m_pend && !(w && ix == 6 && b[0] && d[0]));
        if (w && ix == 0) begin
            t = merge({29'd0, m_ctrl}, d, b);
            m_ctrl = t[2:0];
        end
        if (w && ix == 1) begin
            t = merge({16'd0, m_presc}, d, b);
            m_presc = t[15:0];
        end
        if (w && ix == 4) m_cmp[31:0] = merge(m_cmp[31:0], d, b);
        if (w && ix == 5) m_cmp[63:32] = merge(m_cmp[63:32], d, b);
        m_mtime = nt;
    endtask

    task automatic cyc(input bit req, input bit wr,
                       input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
        @(negedge clk);
        peri_req = req; peri_write = wr; peri_addr = a;
        peri_be = b; peri_wdata = d;
        #1;
        chk("gnt", peri_gnt, req);
        chk("rvalid", peri_rvalid, exp_rvalid);
        chk("rdata", peri_rdata, exp_rdata);
        chk("irq", timer_irq, m_pend && m_ctrl[1]);
        if (fix_en) begin
            chk(fix_tag, peri_rdata, fix_val);
            fix_en = 0;
        end
        @(posedge clk);
        model_step(req, wr, a, b, d);
    endtask

    task automatic wr32(input logic [31:0] off, input logic [31:0] d);
        cyc(1, 1, BASE + off, 4'hF, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a,
                          input logic [31:0] v);
        cyc(1, 0, a, 0, 0);
        fix_en = 1; fix_tag = tag; fix_val = v;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  b;
        bit          rq, w;
        int          ix;

        rst_n = 0; peri_req = 0; peri_write = 0;
        peri_addr = 0; peri_be = 0; peri_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid0", peri_rvalid, 0);
        chk("rst_irq0", timer_irq, 0);
        @(negedge clk);
        rst_n = 1;

        // reset values, back-to-back reads
        for (int i = 0; i < 7; i++)
            rd_exp("rst_reg", BASE + 32'(i * 4), 32'd0);
        idle(1);

        // prescale 3: one tick per 4 cycles
        wr32(32'h04, 3);
        wr32(32'h00, 1);
        idle(40);
        rd_exp("mtime40", BASE + 32'h08, 32'd10);
        idle(1);

        // compare match with irq, then W1C while still matching
        wr32(32'h00, 0);
        wr32(32'h08, 0);
        wr32(32'h0C, 0);
        wr32(32'h18, 1);
        wr32(32'h14, 0);
        wr32(32'h10, 5);
        wr32(32'h04, 0);
        wr32(32'h00, 3);
        idle(8);
        wr32(32'h18, 1);
        #1 chk("irq_after_w1c", timer_irq, 1);
        idle(2);

        // auto reload at compare 4
        wr32(32'h00, 0);
        wr32(32'h08, 0);
        wr32(32'h10, 4);
        wr32(32'h00, 7);
        for (int i = 0; i < 14; i++) cyc(1, 0, BASE + 32'h08, 0, 0);
        rd_exp("pend_sticky", BASE + 32'h18, 32'd1);

        // 32-bit carry into MTIME_HI
        wr32(32'h00, 0);
        wr32(32'h0C, 0);
        wr32(32'h08, 32'hFFFF_FFFF);
        wr32(32'h14, 32'hFFFF_FFFF);
        wr32(32'h00, 1);
        idle(1);
        rd_exp("carry_lo", BASE + 32'h08, 32'd0);
        rd_exp("carry_hi", BASE + 32'h0C, 32'd1);

        // partial byte write
        cyc(1, 1, BASE + 32'h04, 4'b0001, 32'h1234_56AB);
        rd_exp("presc_be", BASE + 32'h04, 32'h0000_00AB);

        // unmapped index and window miss
        rd_exp("idx7", BASE + 32'h1C, 32'd0);
        rd_exp("miss", BASE + 32'h1000, 32'd0);
        cyc(1, 1, BASE + 32'h1C, 4'hF, 32'hFFFF_FFFF);
        cyc(1, 1, BASE + 32'h1000, 4'hF, 32'h0000_0007);
        for (int i = 0; i < 7; i++) cyc(1, 0, BASE + 32'(i * 4), 0, 0);

`ifdef PERI_TIMER_LATCH_EN
        wr32(32'h00, 0);
        wr32(32'h04, 0);
        wr32(32'h0C, 0);
        wr32(32'h08, 32'hFFFF_FFFD);
        wr32(32'h00, 1);
        cyc(1, 0, BASE + 32'h08, 0, 0);
        idle(4);
        rd_exp("latch_hi", BASE + 32'h0C, 32'd0);
        idle(1);
`endif

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rq = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            ix = int'($urandom_range(0, 7));
            a  = BASE + 32'(ix * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a + 32'h1000;
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            if (ix == 0) d = 32'($urandom_range(0, 7));
            if (ix == 1) d = 32'($urandom_range(0, 4));
            if (ix == 5) d = 32'($urandom_range(0, 3));
            if (ix == 3) d = 32'($urandom_range(0, 3));
            cyc(rq, w, a, b, d);
        end

        // reset with a response outstanding
        cyc(1, 0, BASE + 32'h08, 0, 0);
        #1;
        peri_req = 0;
        rst_n = 0;
        #1;
        chk("midrst_rvalid", peri_rvalid, 0);
        chk("midrst_rdata", peri_rdata, 0);
        chk("midrst_irq", timer_irq, 0);
        model_reset();
        fix_en = 0;
        @(negedge clk);
        rst_n = 1;
        idle(3);
        rd_exp("post_rst_lo", BASE + 32'h08, 32'd0);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
